// File: rtl/pool_window_packer.sv
// Strip buffer that turns a raster pixel stream into non-overlapping FILTER_SIZE x FILTER_SIZE
// windows, flattened row-major (index c + r*FILTER_SIZE) for the downstream pool block.
module pool_window_packer #(
  parameter int unsigned FILTER_SIZE = 5,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned IMG_WIDTH   = 20,
  parameter int unsigned IMG_HEIGHT  = 20
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       in_valid_i,
  output logic                                       in_ready_o,
  input  logic [DATA_BITS-1:0]                       in_data_i,
  output logic                                       win_valid_o,
  input  logic                                       win_ready_i,
  output logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] win_data_o,
  output logic                                       win_last_o
);

  localparam int unsigned NumStrips = IMG_HEIGHT / FILTER_SIZE;
  localparam int unsigned ColW      = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned SrowW     = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
  localparam int unsigned StripW    = (NumStrips > 1) ? $clog2(NumStrips) : 1;

  localparam logic [ColW-1:0]   LastCol   = ColW'(IMG_WIDTH - 1);
  localparam logic [ColW-1:0]   LastBase  = ColW'(IMG_WIDTH - FILTER_SIZE);
  localparam logic [ColW-1:0]   BaseStep  = ColW'(FILTER_SIZE);
  localparam logic [SrowW-1:0]  LastSrow  = SrowW'(FILTER_SIZE - 1);
  localparam logic [StripW-1:0] LastStrip = StripW'(NumStrips - 1);

  if (IMG_WIDTH % FILTER_SIZE != 0) begin : g_bad_width
    $error("IMG_WIDTH must be a multiple of FILTER_SIZE");
  end
  if (IMG_HEIGHT % FILTER_SIZE != 0) begin : g_bad_height
    $error("IMG_HEIGHT must be a multiple of FILTER_SIZE");
  end

  typedef enum logic {StFill, StEmit} state_e;

  state_e             state_q, state_d;
  logic [ColW-1:0]    col_q, col_d;
  logic [SrowW-1:0]   srow_q, srow_d;
  logic [StripW-1:0]  strip_q, strip_d;
  // Window counter kept as the first strip column of the current window.
  logic [ColW-1:0]    base_q, base_d;
  logic               pix_acc;

  logic [DATA_BITS-1:0] strip_mem [FILTER_SIZE][IMG_WIDTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StFill;
      col_q   <= '0;
      srow_q  <= '0;
      strip_q <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      srow_q  <= srow_d;
      strip_q <= strip_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    srow_d      = srow_q;
    strip_d     = strip_q;
    base_d      = base_q;
    in_ready_o  = (state_q == StFill);
    win_valid_o = (state_q == StEmit);
    pix_acc     = in_valid_i && in_ready_o;
    unique case (state_q)
      StFill: begin
        if (pix_acc) begin
          if (col_q == LastCol) begin
            col_d = '0;
            if (srow_q == LastSrow) begin
              srow_d  = '0;
              base_d  = '0;
              state_d = StEmit;
            end else begin
              srow_d = srow_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StEmit: begin
        if (win_ready_i) begin
          if (base_q == LastBase) begin
            base_d  = '0;
            col_d   = '0;
            srow_d  = '0;
            strip_d = (strip_q == LastStrip) ? '0 : strip_q + 1'b1;
            state_d = StFill;
          end else begin
            base_d = base_q + BaseStep;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  assign win_last_o = win_valid_o && (base_q == LastBase) && (strip_q == LastStrip);

  for (genvar r = 0; r < FILTER_SIZE; r++) begin : g_row
    for (genvar c = 0; c < IMG_WIDTH; c++) begin : g_col
      logic [DATA_BITS-1:0] pix_q;
      logic                 we;
      assign we = pix_acc && (srow_q == SrowW'(r)) && (col_q == ColW'(c));
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          pix_q <= '0;
        end else if (we) begin
          pix_q <= in_data_i;
        end
      end
      assign strip_mem[r][c] = pix_q;
    end
  end

  for (genvar r = 0; r < FILTER_SIZE; r++) begin : g_win_row
    for (genvar c = 0; c < FILTER_SIZE; c++) begin : g_win_col
      localparam logic [ColW-1:0] ColOff = ColW'(c);
      logic [ColW-1:0] rd_col;
      assign rd_col = base_q + ColOff;
      assign win_data_o[(c + r*FILTER_SIZE)*DATA_BITS +: DATA_BITS] =
          (state_q == StEmit) ? strip_mem[r][rd_col] : '0;
    end
  end

endmodule

// File: tb/tb_pool_window_packer.sv
// Scoreboard bench: a 2x2/4x4 instance for directed cases and a default-parameter instance
// streaming two 20x20 frames.
module tb_pool_window_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Small instance
  logic        s_rst, s_in_valid, s_in_ready, s_win_valid, s_win_ready, s_win_last;
  logic [7:0]  s_in_data;
  logic [31:0] s_win_data;

  pool_window_packer #(
    .FILTER_SIZE(2), .DATA_BITS(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)
  ) dut_s (
    .clk_i(clk), .rst_i(s_rst), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .in_data_i(s_in_data), .win_valid_o(s_win_valid), .win_ready_i(s_win_ready),
    .win_data_o(s_win_data), .win_last_o(s_win_last)
  );

  // Default instance
  logic         d_rst, d_in_valid, d_in_ready, d_win_valid, d_win_ready, d_win_last;
  logic [7:0]   d_in_data;
  logic [199:0] d_win_data;

  pool_window_packer dut_d (
    .clk_i(clk), .rst_i(d_rst), .in_valid_i(d_in_valid), .in_ready_o(d_in_ready),
    .in_data_i(d_in_data), .win_valid_o(d_win_valid), .win_ready_i(d_win_ready),
    .win_data_o(d_win_data), .win_last_o(d_win_last)
  );

  logic [32:0]  s_q[$];
  logic [200:0] d_q[$];
  int d_nwin  = 0;
  int d_nlast = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: sample mid-cycle, a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (!s_rst && s_win_valid && s_win_ready) begin
      logic [32:0] e;
      checks++;
      if (s_q.size() == 0) begin
        errors++;
        $display("FAIL s_extra_window got %0h expected none", s_win_data);
      end else begin
        e = s_q.pop_front();
        if ({s_win_last, s_win_data} !== e) begin
          errors++;
          $display("FAIL s_window got last=%0b data=%h expected last=%0b data=%h",
                   s_win_last, s_win_data, e[32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!d_rst && d_win_valid && d_win_ready) begin
      logic [200:0] e;
      d_nwin++;
      if (d_win_last) d_nlast++;
      checks++;
      if (d_q.size() == 0) begin
        errors++;
        $display("FAIL d_extra_window got %h expected none", d_win_data);
      end else begin
        e = d_q.pop_front();
        if ({d_win_last, d_win_data} !== e) begin
          errors++;
          $display("FAIL d_window%0d got last=%0b data=%h expected last=%0b data=%h",
                   d_nwin, d_win_last, d_win_data, e[200], e[199:0]);
        end
      end
    end
  end

  task automatic s_send(input logic [7:0] d);
    bit done = 0;
    int n = 0;
    s_in_valid = 1'b1;
    s_in_data  = d;
    while (!done) begin
      @(negedge clk);
      if (s_in_ready) done = 1;
      n++;
      if (n > 100) begin
        done = 1;
        chk("s_send_timeout", 1, 0);
      end
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
  endtask

  task automatic d_send(input logic [7:0] d);
    bit done = 0;
    int n = 0;
    d_in_valid = 1'b1;
    d_in_data  = d;
    while (!done) begin
      @(negedge clk);
      if (d_in_ready) done = 1;
      n++;
      if (n > 100) begin
        done = 1;
        chk("d_send_timeout", 1, 0);
      end
      @(posedge clk); #1;
    end
    d_in_valid = 1'b0;
  endtask

  task automatic s_push_frame(input logic [7:0] p0);
    s_q.push_back({1'b0, 24'h050401, p0});
    s_q.push_back({1'b0, 32'h07060302});
    s_q.push_back({1'b0, 32'h0D0C0908});
    s_q.push_back({1'b1, 32'h0F0E0B0A});
  endtask

  task automatic s_frame(input logic [7:0] p0, input bit gaps, input bit lat);
    for (int i = 0; i < 16; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      s_send((i == 0) ? p0 : 8'(i));
      if (lat && i == 6) chk("latency_before", s_win_valid, 0);
      if (lat && i == 7) chk("latency_after", s_win_valid, 1);
    end
  endtask

  task automatic s_drain(input string name);
    repeat (8) begin @(posedge clk); #1; end
    chk(name, s_q.size(), 0);
  endtask

  function automatic logic [7:0] d_pix(input int f, input int idx);
    return 8'((idx * 7 + f * 13) & 255);
  endfunction

  function automatic logic [200:0] d_exp(input int f, input int k);
    logic [200:0] e = '0;
    int s = k / 4;
    int w = k % 4;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        e[(c + r*5)*8 +: 8] = d_pix(f, (s*5 + r)*20 + w*5 + c);
    e[200] = (k == 15);
    return e;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

  initial begin
    s_rst = 1'b1; s_in_valid = 1'b0; s_in_data = '0; s_win_ready = 1'b1;
    d_rst = 1'b1; d_in_valid = 1'b0; d_in_data = '0; d_win_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_in_ready", s_in_ready, 1);
    chk("rst_win_valid", s_win_valid, 0);
    chk("rst_win_last", s_win_last, 0);
    chk("rst_win_data", s_win_data, 0);
    s_rst = 1'b0; d_rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", s_in_ready, 1);

    // Basic stream, no stalls
    s_push_frame(8'h00);
    s_frame(8'h00, 0, 1);
    s_drain("basic_drain");

    // Backpressure with a stray pixel offered during emit
    s_win_ready = 1'b0;
    s_push_frame(8'h00);
    for (int i = 0; i < 8; i++) s_send(8'(i));
    s_in_valid = 1'b1;
    s_in_data  = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_data", s_win_data, 32'h05040100);
      chk("hold_in_ready", s_in_ready, 0);
      @(posedge clk); #1;
    end
    s_in_valid  = 1'b0;
    s_win_ready = 1'b1;
    for (int i = 8; i < 16; i++) s_send(8'(i));
    s_drain("backpressure_drain");

    // Random input bubbles
    s_push_frame(8'h00);
    s_frame(8'h00, 1, 0);
    s_drain("gaps_drain");

    // Reset in the middle of a strip
    for (int i = 0; i < 3; i++) s_send(8'(i + 8'h40));
    s_rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", s_in_ready, 1);
    chk("midrst_win_valid", s_win_valid, 0);
    chk("midrst_win_data", s_win_data, 0);
    s_rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_after_in_ready", s_in_ready, 1);
    s_push_frame(8'h00);
    s_frame(8'h00, 0, 0);
    s_drain("midrst_drain");

    // Signed pixel passes through untouched
    s_push_frame(8'hFD);
    s_frame(8'hFD, 0, 0);
    s_drain("signed_drain");

    // Default parameters, two back-to-back frames
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 16; k++) d_q.push_back(d_exp(f, k));
      for (int i = 0; i < 400; i++) d_send(d_pix(f, i));
    end
    repeat (20) begin @(posedge clk); #1; end
    chk("d_queue_empty", d_q.size(), 0);
    chk("d_window_count", d_nwin, 32);
    chk("d_last_count", d_nlast, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_window_packer.md
# pool_window_packer

- Streaming front end for the max-pool stage. It accepts a raster-order pixel stream with a valid/ready handshake.
- It buffers one strip of FILTER_SIZE image rows. From that strip it emits non-overlapping FILTER_SIZE×FILTER_SIZE windows (stride = FILTER_SIZE), packed in the flattened window format the pooling block consumes.
- It sits between the convolution output stream and the combinational pool/ReLU block.

## Interface

Parameters:
- FILTER_SIZE, 5: window edge and stride.
- DATA_BITS, 8: signed pixel width.
- IMG_WIDTH, 20: pixels per row. Must be a multiple of FILTER_SIZE; violating this is an elaboration error.
- IMG_HEIGHT, 20: rows per frame. Must be a multiple of FILTER_SIZE; violating this is an elaboration error.

Ports:
- clk, in, 1: the single clock.
- rst, in, 1: reset is synchronous and active-high.
- in_valid, in, 1: pixel present.
- in_ready, out, 1: block can accept a pixel.
- in_data, in, DATA_BITS: signed pixel, raster order, row-major within the frame.
- win_valid, out, 1: window present.
- win_ready, in, 1: downstream accepts the window.
- win_data, out, FILTER_SIZE*FILTER_SIZE*DATA_BITS: packed window.
- win_last, out, 1: high with the final window of a frame.

## Operation

- Storage: strip buffer of FILTER_SIZE × IMG_WIDTH entries, DATA_BITS each. The buffer is cleared to 0 on reset.
- Counters:
  - col: 0..IMG_WIDTH-1
  - srow: 0..FILTER_SIZE-1
  - strip: 0..IMG_HEIGHT/FILTER_SIZE-1
  - win: 0..IMG_WIDTH/FILTER_SIZE-1
- State FILL:
  - in_ready=1, win_valid=0.
  - On in_valid&&in_ready, store in_data at buffer[srow][col], then increment col.
  - When col wraps, increment srow.
  - Accepting the pixel with srow=FILTER_SIZE-1 and col=IMG_WIDTH-1 moves the block to EMIT with win=0.
- State EMIT:
  - in_ready=0; in_valid is ignored.
  - win_valid=1. win_data covers strip columns win*FILTER_SIZE .. win*FILTER_SIZE+FILTER_SIZE-1.
  - On win_valid&&win_ready, increment win.
  - When the window with win=IMG_WIDTH/FILTER_SIZE-1 is accepted, return to FILL with col=0 and srow=0, and increment strip (wrapping to 0 after the last strip).
- Packing: the element at window row r, column c goes to index i = c + r*FILTER_SIZE, at bits [i*DATA_BITS +: DATA_BITS]. Pixel bits pass through unmodified: no sign change, no clipping, no ReLU.
- win_last = win_valid && (win == IMG_WIDTH/FILTER_SIZE-1) && (strip == IMG_HEIGHT/FILTER_SIZE-1).
- After the final window of a frame is accepted, all counters are 0. The next pixel starts a new frame.
- No framing input exists. Frame alignment is purely by count; a resync requires rst.

## Timing

- Reset values: in_ready=1, win_valid=0, win_last=0, win_data=0. State is FILL and all counters are 0.
- Reset mid-operation discards any partial strip or pending windows. In the cycle after rst deasserts, in_ready=1.
- Latency: if the last pixel of a strip is accepted in cycle N, win_valid=1 in cycle N+1.
- Throughput:
  - One window per cycle while win_ready=1.
  - One strip costs FILTER_SIZE*IMG_WIDTH input beats plus IMG_WIDTH/FILTER_SIZE output beats. Input is stalled during EMIT.
- If the last window of a strip is accepted in cycle M, in_ready=1 in cycle M+1.
- Output hold: while win_valid=1 and win_ready=0, win_data and win_last stay stable. The buffer is never written in EMIT.
- win_ready has no effect in FILL. in_valid has no effect in EMIT.
- win_valid never depends combinationally on win_ready. in_ready never depends combinationally on in_valid.

## Test plan

Tests 1–4 use FILTER_SIZE=2, DATA_BITS=8, IMG_WIDTH=4, IMG_HEIGHT=4, with pixel value = raster index 0..15.

- **Basic fill/emit, no stalls.** Stream 16 pixels with in_valid=1 and win_ready=1.
  - Windows, in order: 0x05040100, 0x07060302, 0x0D0C0908, 0x0F0E0B0A.
  - win_last=1 only on 0x0F0E0B0A.
  - win_valid rises exactly one cycle after pixel 7 is accepted.
- **Backpressure.** Hold win_ready=0 for 5 cycles after win_valid rises.
  - win_data stays 0x05040100 and in_ready stays 0.
  - Releasing win_ready yields the remaining windows unchanged.
- **Input gaps.** Insert random in_valid=0 bubbles.
  - Window contents are identical to the no-stall test.
  - Pixels offered with in_valid=1 during EMIT are not consumed.
- **Reset mid-strip.** Assert rst after 3 pixels.
  - Outputs go to reset values the next cycle.
  - Then stream a full frame: the first window is 0x05040100.
- **Signed passthrough.** Set pixel 0 = -3.
  - The first window's low byte is 0xFD; no clipping occurs.
- **Default parameters.** Two back-to-back 20×20 frames.
  - 16 windows per frame, with win_last on windows 16 and 32 only.
  - Second-frame contents are correct, confirming counter wrap.
